// File: rtl/rect_pixel_streamer_if.sv
// Command and pixel-stream bundle for rect_pixel_streamer.
// master: command source and pixel sink; slave: the streamer itself.
interface rect_pixel_streamer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_x;
  logic [10:0] cmd_y;
  logic [10:0] cmd_w;
  logic [10:0] cmd_h;
  logic [7:0]  cmd_color;
  logic [63:0] cmd_mask;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [10:0] width;
  logic [10:0] height;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        draw;
  logic        pixel_ready;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mask, pixel_ready,
    input  cmd_ready, pixel_x, pixel_y, width, height, pixel_data, pixel_valid, draw,
           busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mask, pixel_ready,
    output cmd_ready, pixel_x, pixel_y, width, height, pixel_data, pixel_valid, draw,
           busy, done
  );
endinterface

// File: rtl/rect_pixel_streamer.sv
// Rectangle-fill pixel source: accepts one command, clips it to the framebuffer and
// streams the clipped rectangle row-major with a valid/ready handshake.
// Optional feature: define RPS_MASK_EN to gate 'draw' with a tiled 8x8 mask.
module rect_pixel_streamer #(
  parameter int unsigned FB_WIDTH  = 800,
  parameter int unsigned FB_HEIGHT = 600
) (
  input logic                  clk,
  input logic                  reset_n,
  rect_pixel_streamer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClip, StStream, StDone} state_e;

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [7:0]  color_q, color_d;
  logic [10:0] wc_q, wc_d, hc_q, hc_d;
  logic [10:0] col_q, col_d, row_q, row_d;
  logic [10:0] px_q, px_d, py_q, py_d;

  logic        accept;
  logic        last_col, last_row;
  logic [11:0] fb_w, fb_h, room_x, room_y, w_clip, h_clip;

  assign accept = (state_q == StIdle) && bus.cmd_valid;
  assign fb_w   = 12'(FB_WIDTH);
  assign fb_h   = 12'(FB_HEIGHT);

  // Clip the latched command; 12-bit arithmetic so origin + size cannot overflow.
  always_comb begin
    room_x = fb_w - {1'b0, x_q};
    room_y = fb_h - {1'b0, y_q};
    w_clip = '0;
    h_clip = '0;
    if ({1'b0, x_q} < fb_w) begin
      w_clip = ({1'b0, w_q} < room_x) ? {1'b0, w_q} : room_x;
    end
    if ({1'b0, y_q} < fb_h) begin
      h_clip = ({1'b0, h_q} < room_y) ? {1'b0, h_q} : room_y;
    end
  end

  assign last_col = (col_q == wc_q - 11'd1);
  assign last_row = (row_q == hc_q - 11'd1);

  // Next-state and datapath update for the command FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    wc_d    = wc_q;
    hc_d    = hc_q;
    col_d   = col_q;
    row_d   = row_q;
    px_d    = px_q;
    py_d    = py_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          x_d     = bus.cmd_x;
          y_d     = bus.cmd_y;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
          color_d = bus.cmd_color;
          state_d = StClip;
        end
      end
      StClip: begin
        wc_d    = w_clip[10:0];
        hc_d    = h_clip[10:0];
        col_d   = '0;
        row_d   = '0;
        px_d    = x_q;
        py_d    = y_q;
        // An empty clipped rectangle finishes without emitting any beat.
        state_d = ((w_clip == '0) || (h_clip == '0)) ? StDone : StStream;
      end
      StStream: begin
        if (bus.pixel_ready) begin
          if (!last_col) begin
            col_d = col_q + 11'd1;
            px_d  = px_q + 11'd1;
          end else if (!last_row) begin
            col_d = '0;
            row_d = row_q + 11'd1;
            px_d  = x_q;
            py_d  = py_q + 11'd1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Command, clip result and scan-position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      wc_q    <= '0;
      hc_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      wc_q    <= wc_d;
      hc_q    <= hc_d;
      col_q   <= col_d;
      row_q   <= row_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.pixel_valid = (state_q == StStream);
  assign bus.pixel_x     = px_q;
  assign bus.pixel_y     = py_q;
  assign bus.width       = wc_q;
  assign bus.height      = hc_q;
  assign bus.pixel_data  = color_q;

`ifdef RPS_MASK_EN
  logic [63:0] mask_q;
  logic [5:0]  mask_idx;

  // Capture the draw mask alongside the other command fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= bus.cmd_mask;
    end
  end

  // Mask tiles every 8 pixels from the rectangle origin.
  assign mask_idx = {row_q[2:0], col_q[2:0]};
  assign bus.draw = bus.pixel_valid & mask_q[mask_idx];
`else
  logic unused_mask;
  logic unused_accept;

  assign unused_mask   = ^bus.cmd_mask;
  assign unused_accept = accept;
  assign bus.draw      = bus.pixel_valid;
`endif

endmodule

// File: tb/tb_rect_pixel_streamer.sv
// Directed bench for rect_pixel_streamer: reset, basic fill, clipping, empty commands,
// back-pressure, 1x1, reset mid-command and the draw mask.
module tb_rect_pixel_streamer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  rect_pixel_streamer_if bus ();

  rect_pixel_streamer #(
    .FB_WIDTH (800),
    .FB_HEIGHT(600)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Results captured by run_cmd.
  logic [10:0] bx[$];
  logic [10:0] by[$];
  logic [7:0]  bdat[$];
  logic        bdraw[$];
  int          first_valid_cyc, last_beat_cyc, done_cyc, done_cnt;
  logic        valid_drop, hold_err, wh_changed, ready_after_done, accept_ok;
  logic [10:0] w_seen, h_seen;

  task automatic drive_idle();
    bus.cmd_valid   = 1'b0;
    bus.cmd_x       = '0;
    bus.cmd_y       = '0;
    bus.cmd_w       = '0;
    bus.cmd_h       = '0;
    bus.cmd_color   = '0;
    bus.cmd_mask    = '0;
    bus.pixel_ready = 1'b0;
  endtask

  // Issue one command and record the stream. mode 0: ready always high; mode 1: 1,0,1,0...
  task automatic run_cmd(input logic [10:0] x, input logic [10:0] y, input logic [10:0] w,
                         input logic [10:0] h, input logic [7:0] c, input logic [63:0] m,
                         input int mode, input int budget);
    logic        prev_wait;
    logic [10:0] prevx, prevy;
    bx.delete(); by.delete(); bdat.delete(); bdraw.delete();
    first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1; done_cnt = 0;
    valid_drop = 1'b0; hold_err = 1'b0; wh_changed = 1'b0; ready_after_done = 1'b0;
    w_seen = '0; h_seen = '0;
    prev_wait = 1'b0; prevx = '0; prevy = '0;
    @(negedge clk);
    accept_ok     = bus.cmd_ready;
    bus.cmd_valid = 1'b1;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_w     = w;
    bus.cmd_h     = h;
    bus.cmd_color = c;
    bus.cmd_mask  = m;
    bus.pixel_ready = (mode == 0);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      bus.cmd_valid   = 1'b0;
      bus.cmd_mask    = '0;
      bus.pixel_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.pixel_valid) begin
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          w_seen = bus.width;
          h_seen = bus.height;
        end else if (bus.width !== w_seen || bus.height !== h_seen) begin
          wh_changed = 1'b1;
        end
        if (prev_wait && (bus.pixel_x !== prevx || bus.pixel_y !== prevy)) hold_err = 1'b1;
        prev_wait = !bus.pixel_ready;
        prevx = bus.pixel_x;
        prevy = bus.pixel_y;
        if (bus.pixel_ready) begin
          bx.push_back(bus.pixel_x);
          by.push_back(bus.pixel_y);
          bdat.push_back(bus.pixel_data);
          bdraw.push_back(bus.draw);
          last_beat_cyc = cyc;
        end
      end else begin
        if (first_valid_cyc >= 0 && !bus.done && done_cyc < 0) valid_drop = 1'b1;
        prev_wait = 1'b0;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        ready_after_done = bus.cmd_ready && !bus.busy && !bus.done;
        break;
      end
    end
    bus.pixel_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.pixel_valid, bus.draw} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=10000",
               {bus.cmd_ready, bus.busy, bus.done, bus.pixel_valid, bus.draw});
    end
    checks++;
    if ({bus.pixel_x, bus.pixel_y, bus.width, bus.height, bus.pixel_data} !== '0) begin
      failures++;
      $display("FAIL reset_data x=%0d y=%0d w=%0d h=%0d d=%0h want all 0", bus.pixel_x,
               bus.pixel_y, bus.width, bus.height, bus.pixel_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [10:0] ex, ey;
    run_cmd(11'd10, 11'd20, 11'd3, 11'd2, 8'hA5, '1, 0, 40);
    checks++;
    if (accept_ok !== 1'b1) begin
      failures++;
      $display("FAIL t1_accept cmd_ready=%b want 1", accept_ok);
    end
    checks++;
    if (bx.size() != 6) begin
      failures++;
      $display("FAIL t1_beats got=%0d want=6", bx.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        ex = 11'(10 + i % 3);
        ey = 11'(20 + i / 3);
        checks++;
        if (bx[i] !== ex || by[i] !== ey || bdat[i] !== 8'hA5 || bdraw[i] !== 1'b1) begin
          failures++;
          $display("FAIL t1_beat%0d got=(%0d,%0d,%h,%b) want=(%0d,%0d,a5,1)", i, bx[i], by[i],
                   bdat[i], bdraw[i], ex, ey);
        end
      end
    end
    checks++;
    if (first_valid_cyc != 2) begin
      failures++;
      $display("FAIL t1_latency first valid cycle=%0d want=2", first_valid_cyc);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin
      failures++;
      $display("FAIL t1_done count=%0d cyc=%0d want 1 at %0d", done_cnt, done_cyc,
               last_beat_cyc + 1);
    end
    checks++;
    if (w_seen !== 11'd3 || h_seen !== 11'd2 || wh_changed || valid_drop) begin
      failures++;
      $display("FAIL t1_size w=%0d h=%0d chg=%b drop=%b want 3 2 0 0", w_seen, h_seen,
               wh_changed, valid_drop);
    end
    checks++;
    if (ready_after_done !== 1'b1) begin
      failures++;
      $display("FAIL t1_idle_after_done got=%b want=1", ready_after_done);
    end
  endtask

  task automatic test_clip();
    run_cmd(11'd790, 11'd595, 11'd40, 11'd10, 8'h3C, '1, 0, 120);
    checks++;
    if (w_seen !== 11'd10 || h_seen !== 11'd5 || wh_changed) begin
      failures++;
      $display("FAIL t2_size w=%0d h=%0d chg=%b want 10 5 0", w_seen, h_seen, wh_changed);
    end
    checks++;
    if (bx.size() != 50) begin
      failures++;
      $display("FAIL t2_beats got=%0d want=50", bx.size());
    end else begin
      checks++;
      if (bx[0] !== 11'd790 || by[0] !== 11'd595 || bx[49] !== 11'd799 || by[49] !== 11'd599)
      begin
        failures++;
        $display("FAIL t2_corners first=(%0d,%0d) last=(%0d,%0d) want (790,595) (799,599)",
                 bx[0], by[0], bx[49], by[49]);
      end
      checks++;
      if (bx[10] !== 11'd790 || by[10] !== 11'd596) begin
        failures++;
        $display("FAIL t2_wrap beat10=(%0d,%0d) want (790,596)", bx[10], by[10]);
      end
    end
    checks++;
    if (done_cnt != 1 || valid_drop) begin
      failures++;
      $display("FAIL t2_done count=%0d drop=%b want 1 0", done_cnt, valid_drop);
    end
  endtask

  task automatic test_empty();
    logic [10:0] xs[3];
    logic [10:0] ys[3];
    logic [10:0] ws[3];
    xs = '{11'd800, 11'd5, 11'd5};
    ys = '{11'd5, 11'd5, 11'd600};
    ws = '{11'd4, 11'd0, 11'd4};
    for (int k = 0; k < 3; k++) begin
      run_cmd(xs[k], ys[k], ws[k], 11'd4, 8'h11, '1, 0, 20);
      checks++;
      if (first_valid_cyc >= 0 || bx.size() != 0) begin
        failures++;
        $display("FAIL t3_novalid_%0d first_valid=%0d beats=%0d want none", k,
                 first_valid_cyc, bx.size());
      end
      checks++;
      if (done_cnt != 1 || done_cyc < 2 || done_cyc > 3 || !ready_after_done) begin
        failures++;
        $display("FAIL t3_done_%0d count=%0d cyc=%0d idle=%b want 1 in 2..3 1", k, done_cnt,
                 done_cyc, ready_after_done);
      end
    end
  endtask

  task automatic test_backpressure();
    run_cmd(11'd100, 11'd50, 11'd20, 11'd1, 8'h5A, '1, 1, 100);
    checks++;
    if (bx.size() != 20) begin
      failures++;
      $display("FAIL t4_beats got=%0d want=20", bx.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (bx[i] !== 11'(100 + i) || by[i] !== 11'd50) begin
          failures++;
          $display("FAIL t4_beat%0d got=(%0d,%0d) want=(%0d,50)", i, bx[i], by[i], 100 + i);
        end
      end
    end
    checks++;
    if (valid_drop || hold_err || done_cnt != 1) begin
      failures++;
      $display("FAIL t4_flow drop=%b hold_err=%b done=%0d want 0 0 1", valid_drop, hold_err,
               done_cnt);
    end
  endtask

  task automatic test_single();
    run_cmd(11'd799, 11'd599, 11'd1, 11'd1, 8'h77, '1, 0, 20);
    checks++;
    if (bx.size() != 1 || bx[0] !== 11'd799 || by[0] !== 11'd599 || bdat[0] !== 8'h77) begin
      failures++;
      $display("FAIL t1x1_beat beats=%0d want one beat at (799,599) data 77", bx.size());
    end
    checks++;
    if (first_valid_cyc != 2 || done_cyc != 3 || w_seen !== 11'd1 || h_seen !== 11'd1) begin
      failures++;
      $display("FAIL t1x1_timing valid=%0d done=%0d w=%0d h=%0d want 2 3 1 1", first_valid_cyc,
               done_cyc, w_seen, h_seen);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    int dones;
    nb = 0;
    dones = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = 11'd0;
    bus.cmd_y = 11'd0;
    bus.cmd_w = 11'd4;
    bus.cmd_h = 11'd4;
    bus.cmd_color = 8'hC3;
    bus.cmd_mask = '1;
    bus.pixel_ready = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.pixel_valid) begin
        if (nb == 4) break;
        nb++;
      end
    end
    checks++;
    if (nb != 4 || !bus.pixel_valid || bus.pixel_x !== 11'd0 || bus.pixel_y !== 11'd1) begin
      failures++;
      $display("FAIL t5_beat5 nb=%0d valid=%b at=(%0d,%0d) want 4 1 (0,1)", nb,
               bus.pixel_valid, bus.pixel_x, bus.pixel_y);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.pixel_valid, bus.draw} !== 5'b10000 ||
        {bus.pixel_x, bus.pixel_y, bus.width, bus.height, bus.pixel_data} !== '0) begin
      failures++;
      $display("FAIL t5_async_reset ctrl=%b x=%0d y=%0d w=%0d want 10000 0 0 0",
               {bus.cmd_ready, bus.busy, bus.done, bus.pixel_valid, bus.draw}, bus.pixel_x,
               bus.pixel_y, bus.width);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL t5_no_done got=%0d busy/done cycles want=0", dones);
    end
    run_cmd(11'd5, 11'd6, 11'd2, 11'd2, 8'h42, '1, 0, 30);
    checks++;
    if (bx.size() != 4 || bx[0] !== 11'd5 || by[0] !== 11'd6 || bx[3] !== 11'd6 ||
        by[3] !== 11'd7 || done_cnt != 1) begin
      failures++;
      $display("FAIL t5_next_cmd beats=%0d done=%0d want 4 beats (5,6)..(6,7) done 1",
               bx.size(), done_cnt);
    end
  endtask

`ifdef RPS_MASK_EN
  task automatic test_mask();
    logic want;
    run_cmd(11'd0, 11'd0, 11'd8, 11'd2, 8'hEE, 64'h00000000_000000AA, 0, 40);
    checks++;
    if (bx.size() != 16) begin
      failures++;
      $display("FAIL t6_beats got=%0d want=16", bx.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        want = (i < 8) && (i % 2 == 1);
        checks++;
        if (bdraw[i] !== want) begin
          failures++;
          $display("FAIL t6_draw%0d got=%b want=%b", i, bdraw[i], want);
        end
      end
    end
  endtask
`else
  task automatic test_mask();
    run_cmd(11'd0, 11'd0, 11'd8, 11'd2, 8'hEE, 64'h00000000_000000AA, 0, 40);
    checks++;
    if (bx.size() != 16) begin
      failures++;
      $display("FAIL mask_ignored_beats got=%0d want=16", bx.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (bdraw[i] !== 1'b1) begin
          failures++;
          $display("FAIL mask_ignored_draw%0d got=%b want=1", i, bdraw[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_backpressure();
    test_single();
    test_reset_mid();
    test_mask();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
